posit_cop_seq: RTL and testbench

POSIT_COP_SEQ -- requirements
Module: posit_cop_seq

---
 rtl/posit_cop_seq.sv | 215 +++++++++++++++++++++
 tb/tb_posit_cop_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_cop_seq.sv
// Bus-attached sequencer for NUM_OPS posit operator units. Results are queued in a small FIFO.
// Define POSIT_COP_SEQ_TIMEOUT_EN to add a watchdog that abandons a WAIT lasting TIMEOUT cycles.
module posit_cop_seq #(
    parameter int N          = 32,
    parameter int NUM_OPS    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [N-1:0]         opa_o,
    output logic [N-1:0]         opb_o,
    output logic [NUM_OPS-1:0]   start_o,
    input  logic [NUM_OPS-1:0]   done_i,
    input  logic [NUM_OPS*N-1:0] result_i,
    input  logic [NUM_OPS-1:0]   inf_i,
    input  logic [NUM_OPS-1:0]   zero_i
);
    localparam int SEL_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] ADDR_OPA  = 5'h00;
    localparam logic [4:0] ADDR_OPB  = 5'h04;
    localparam logic [4:0] ADDR_CMD  = 5'h08;
    localparam logic [4:0] ADDR_STAT = 5'h0C;
    localparam logic [4:0] ADDR_RES  = 5'h10;
    localparam logic [3:0] CMD_MAX   = 4'(NUM_OPS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return m;
    endfunction

    state_t             state_r;
    logic [SEL_W-1:0]   sel_r;
    logic [N-1:0]       opa_r, opb_r, res_r;
    logic               inf_r, zero_r;
    logic               err_r, last_inf_r, last_zero_r;
    logic [N+1:0]       fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_r, rptr_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [4:0]  adr_s;
    logic [3:0]  cmd_s;
    logic        wr_s, rd_s, empty_s, full_s, busy_s;
    logic        cmd_wr_s, cmd_ok_s, cmd_acc_s, cmd_drop_s;
    logic        pop_s, pop_empty_s, push_s, err_clr_s, done_sel_s, timeout_s;
    logic [N+1:0] head_s;
    logic [31:0] status_s, rd_val_s;
    logic        unused_addr_s;

`ifdef POSIT_COP_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_r;
`endif

    assign unused_addr_s = ^addr_i[31:5];

    // Bus decode, command qualification, FIFO flags and read-data selection
    always_comb begin
        adr_s       = addr_i[4:0];
        cmd_s       = wdata_i[3:0];
        wr_s        = req_i & we_i;
        rd_s        = req_i & ~we_i;
        empty_s     = (cnt_r == {CNT_W{1'b0}});
        full_s      = (cnt_r == CNT_FULL);
        busy_s      = (state_r != ST_IDLE);
        cmd_wr_s    = wr_s & (adr_s == ADDR_CMD);
        cmd_ok_s    = ~busy_s & ~full_s & (cmd_s >= 4'd1) & (cmd_s <= CMD_MAX);
        cmd_acc_s   = cmd_wr_s & cmd_ok_s;
        cmd_drop_s  = cmd_wr_s & ~cmd_ok_s;
        pop_s       = rd_s & (adr_s == ADDR_RES) & ~empty_s;
        pop_empty_s = rd_s & (adr_s == ADDR_RES) & empty_s;
        push_s      = (state_r == ST_PUSH);
        err_clr_s   = wr_s & (adr_s == ADDR_STAT) & wdata_i[3];
        done_sel_s  = done_i[sel_r];
        head_s      = fifo_r[rptr_r];
`ifdef POSIT_COP_SEQ_TIMEOUT_EN
        timeout_s   = (state_r == ST_WAIT) & ~done_sel_s & (tmr_r == TMR_W'(TIMEOUT - 1));
`else
        timeout_s   = 1'b0;
`endif
        status_s    = {19'd0, 5'(cnt_r), 2'd0, last_zero_r, last_inf_r,
                       err_r, full_s, empty_s, busy_s};
        case (adr_s)
            ADDR_OPA:  rd_val_s = 32'(opa_r);
            ADDR_OPB:  rd_val_s = 32'(opb_r);
            ADDR_STAT: rd_val_s = status_s;
            ADDR_RES:  rd_val_s = empty_s ? 32'd0 : 32'(head_s[N-1:0]);
            default:   rd_val_s = 32'd0;
        endcase
    end

    // Operation sequencer: snapshot operands, pulse start, wait for the selected unit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            start_o <= {NUM_OPS{1'b0}};
            opa_o   <= {N{1'b0}};
            opb_o   <= {N{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            res_r   <= {N{1'b0}};
            inf_r   <= 1'b0;
            zero_r  <= 1'b0;
`ifdef POSIT_COP_SEQ_TIMEOUT_EN
            tmr_r   <= {TMR_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_acc_s) begin
                        state_r <= ST_START;
                        opa_o   <= opa_r;
                        opb_o   <= opb_r;
                        sel_r   <= SEL_W'(cmd_s - 4'd1);
                        start_o <= NUM_OPS'(1'b1) << (cmd_s - 4'd1);
                    end
                end
                ST_START: begin
                    start_o <= {NUM_OPS{1'b0}};
                    state_r <= ST_WAIT;
`ifdef POSIT_COP_SEQ_TIMEOUT_EN
                    tmr_r   <= {TMR_W{1'b0}};
`endif
                end
                ST_WAIT: begin
                    if (done_sel_s) begin
                        res_r   <= result_i[sel_r*N +: N];
                        inf_r   <= inf_i[sel_r];
                        zero_r  <= zero_i[sel_r];
                        state_r <= ST_PUSH;
`ifdef POSIT_COP_SEQ_TIMEOUT_EN
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        tmr_r   <= tmr_r + TMR_W'(1);
`endif
                    end
                end
                ST_PUSH: state_r <= ST_IDLE;
                default: begin
                    state_r <= ST_IDLE;
                    start_o <= {NUM_OPS{1'b0}};
                end
            endcase
        end
    end

    // Operand registers, sticky error, last-popped flags and the one-cycle bus response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opa_r       <= {N{1'b0}};
            opb_r       <= {N{1'b0}};
            err_r       <= 1'b0;
            last_inf_r  <= 1'b0;
            last_zero_r <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= 32'd0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd_s ? rd_val_s : 32'd0;
            if (wr_s && adr_s == ADDR_OPA) opa_r <= N'(merge_bytes(32'(opa_r), wdata_i, be_i));
            if (wr_s && adr_s == ADDR_OPB) opb_r <= N'(merge_bytes(32'(opb_r), wdata_i, be_i));
            // a set in the same cycle as a clear wins
            if (cmd_drop_s || pop_empty_s || timeout_s) err_r <= 1'b1;
            else if (err_clr_s)                         err_r <= 1'b0;
            if (pop_s) begin
                last_inf_r  <= head_s[N+1];
                last_zero_r <= head_s[N];
            end
        end
    end

    // Result FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wptr_r <= wptr_r + PTR_W'(1);
            if (pop_s)  rptr_r <= rptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Result FIFO storage, entry layout {inf, zero, result}
    always_ff @(posedge clk_i) begin
        if (push_s) fifo_r[wptr_r] <= {inf_r, zero_r, res_r};
    end
endmodule

// File: tb/tb_posit_cop_seq.sv
// Self-checking bench for posit_cop_seq: register table, hand-written sequences and a random
// run against a cycle-count reference model with an emulated set of operator units.
module tb_posit_cop_seq;
    localparam int N = 32;
    localparam int NUM_OPS = 3;
    localparam logic [31:0] A_OPA = 32'h00, A_OPB = 32'h04, A_CMD = 32'h08;
    localparam logic [31:0] A_STAT = 32'h0C, A_RES = 32'h10;

    logic clk = 1'b0;
    logic rst_i, req_i, we_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [3:0] be_i;
    logic rvalid_o;
    logic [N-1:0] opa_o, opb_o;
    logic [NUM_OPS-1:0] start_o, done_i, inf_i, zero_i, rsp_done, man_done;
    logic [NUM_OPS*N-1:0] result_i;

    assign done_i = rsp_done | man_done;
    always #5 clk = ~clk;

    posit_cop_seq #(.N(N), .NUM_OPS(NUM_OPS), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .opa_o(opa_o), .opb_o(opb_o), .start_o(start_o), .done_i(done_i),
        .result_i(result_i), .inf_i(inf_i), .zero_i(zero_i));

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int start_pulses [NUM_OPS];
    int start_bad = 0;
    bit resp_en = 1'b0, resp_fixed_en = 1'b0;
    int resp_delay = 1;
    logic [31:0] resp_fixed = 32'd0;
    logic [33:0] q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < NUM_OPS; k++) if (start_o[k] === 1'b1) start_pulses[k]++;
        if ($countones(start_o) > 1) start_bad++;
    end

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input int k);
        return a * 32'd3 + {b[15:0], b[31:16]} + 32'(k) * 32'h01010101;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] m;
        m = o;
        for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = w[b*8 +: 8];
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // caller is positioned at a negedge; response is sampled at the following negedge
    task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, output logic [31:0] rd, output logic rv);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = data; be_i = be;
        @(negedge clk);
        rd = rdata_o; rv = rvalid_o;
        req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; be_i = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d; logic v;
        bus(1'b1, addr, data, 4'hF, d, v);
        check("wr_rvalid", {31'd0, v}, 32'd1);
        check("wr_rdata", d, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        logic v;
        bus(1'b0, addr, 32'd0, 4'h0, d, v);
        check("rd_rvalid", {31'd0, v}, 32'd1);
    endtask

    task automatic wait_idle();
        logic [31:0] s; int n;
        n = 0; s = 32'd1;
        while (s[0] && n < 200) begin rd(A_STAT, s); n++; end
        if (s[0]) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d polls", n);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd0);
        check({tag, "_rdata"}, rdata_o, 32'd0);
        check({tag, "_start"}, 32'(start_o), 32'd0);
        check({tag, "_opa_o"}, opa_o, 32'd0);
        check({tag, "_opb_o"}, opb_o, 32'd0);
    endtask

    // Emulated operator units: answer a start after resp_delay cycles, with a stray done from
    // another unit early in the wait
    initial begin
        rsp_done = '0; result_i = '0; inf_i = '0; zero_i = '0;
        forever begin
            @(negedge clk);
            if (resp_en && start_o != '0) begin
                int k, d, o;
                logic [31:0] v;
                k = 0;
                for (int i = 0; i < NUM_OPS; i++) if (start_o[i]) k = i;
                d = resp_delay;
                v = resp_fixed_en ? resp_fixed : unit_fn(opa_o, opb_o, k);
                o = (k + 1) % NUM_OPS;
                if (d >= 2) begin
                    @(negedge clk);
                    rsp_done[o] = 1'b1; result_i[o*N +: N] = 32'hDEADBEEF; inf_i[o] = 1'b1; zero_i[o] = 1'b1;
                    @(negedge clk);
                    rsp_done = '0; inf_i = '0; zero_i = '0;
                    repeat (d - 2) @(negedge clk);
                end else begin
                    @(negedge clk);
                end
                rsp_done[k] = 1'b1; result_i[k*N +: N] = v; inf_i[k] = v[0]; zero_i[k] = v[1];
                @(negedge clk);
                rsp_done = '0; inf_i = '0; zero_i = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [25];

    initial begin
        logic [31:0] d, s, v, m_opa, m_opb, exp, wdv;
        logic rv, m_err, m_li, m_lz, idle, pend_valid;
        logic [33:0] pend_entry, head;
        int n, p0, p1, c, op, cmdv, dly, busy_until, pend_vis;
        logic [3:0] bev;

        for (int k = 0; k < NUM_OPS; k++) start_pulses[k] = 0;
        vt[0]  = '{1'b1, 8'h00, 32'h12345678, 4'hF, 32'h0};
        vt[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h12345678};
        vt[2]  = '{1'b1, 8'h00, 32'hAABBCCDD, 4'h5, 32'h0};
        vt[3]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h12BB56DD};
        vt[4]  = '{1'b1, 8'h04, 32'hFFFFFFFF, 4'h8, 32'h0};
        vt[5]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'hFF000000};
        vt[6]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h00000002};
        vt[7]  = '{1'b1, 8'h08, 32'h00000000, 4'hF, 32'h0};
        vt[8]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0000000A};
        vt[9]  = '{1'b1, 8'h0C, 32'h00000008, 4'hF, 32'h0};
        vt[10] = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h00000002};
        vt[11] = '{1'b1, 8'h08, 32'h00000004, 4'hF, 32'h0};
        vt[12] = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0000000A};
        vt[13] = '{1'b1, 8'h0C, 32'h00000007, 4'hF, 32'h0};
        vt[14] = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0000000A};
        vt[15] = '{1'b1, 8'h0C, 32'h00000008, 4'hF, 32'h0};
        vt[16] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h0};
        vt[17] = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0000000A};
        vt[18] = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h0};
        vt[19] = '{1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0};
        vt[20] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'h0};
        vt[21] = '{1'b0, 8'h01, 32'h0,        4'h0, 32'h0};
        vt[22] = '{1'b1, 8'h0C, 32'h00000008, 4'hF, 32'h0};
        vt[23] = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h00000002};
        vt[24] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h12BB56DD};

        man_done = '0; we_i = 1'b0; be_i = 4'd0; wdata_i = 32'd0;
        // reset dominates a pending read request
        rst_i = 1'b1; req_i = 1'b1; addr_i = A_STAT;
        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst_i = 1'b0; req_i = 1'b0; addr_i = 32'd0;
        @(negedge clk);
        check("idle_rvalid", {31'd0, rvalid_o}, 32'd0);

        for (int i = 0; i < 25; i++) begin
            bus(vt[i].we, {24'd0, vt[i].addr}, vt[i].wdata, vt[i].be, d, rv);
            check($sformatf("vec%0d", i), d, vt[i].exp);
            check($sformatf("vec%0d_rvalid", i), {31'd0, rv}, 32'd1);
        end

        // basic operation with start/done latency
        do_reset();
        wr(A_OPA, 32'h40000000); wr(A_OPB, 32'h40000000);
        resp_en = 1'b1; resp_fixed_en = 1'b1; resp_fixed = 32'h48000000; resp_delay = 5;
        p0 = start_pulses[0];
        wr(A_CMD, 32'd1);
        check("start_001", 32'(start_o), 32'h1);
        check("snap_opa", opa_o, 32'h40000000);
        check("snap_opb", opb_o, 32'h40000000);
        @(negedge clk);
        check("start_off", 32'(start_o), 32'h0);
        n = 0; s = 32'd0;
        while (s[12:8] == 5'd0 && n < 40) begin rd(A_STAT, s); n++; end
        check("push_latency", n, 7);
        check("stat_count1", s, 32'h00000100);
        check("start_pulse_once", start_pulses[0] - p0, 1);
        rd(A_RES, d); check("result_021", d, 32'h48000000);
        rd(A_STAT, d); check("stat_empty_after_pop", d, 32'h00000002);

        // command while busy is dropped
        resp_fixed = 32'h11111111; resp_delay = 10;
        p1 = start_pulses[1];
        wr(A_CMD, 32'd1);
        wr(A_CMD, 32'd2);
        rd(A_STAT, d); check("stat_busy_err", d, 32'h0000000B);
        wait_idle();
        rd(A_STAT, d); check("stat_done_err", d, 32'h00000108);
        check("no_start_unit1", start_pulses[1] - p1, 0);
        rd(A_RES, d); check("result_022", d, 32'h11111111);
        wr(A_STAT, 32'h8);
        rd(A_STAT, d); check("stat_err_cleared", d, 32'h00000012);

        // fill the FIFO, then a command must be refused
        do_reset();
        resp_delay = 3;
        for (int i = 0; i < 4; i++) begin
            resp_fixed = 32'hA0000010 | 32'(i);
            wr(A_CMD, 32'd1);
            wait_idle();
        end
        rd(A_STAT, d); check("stat_full", d, 32'h00000404);
        p0 = start_pulses[0];
        wr(A_CMD, 32'd1);
        repeat (3) @(negedge clk);
        check("no_start_when_full", start_pulses[0] - p0, 0);
        rd(A_STAT, d); check("stat_full_err", d, 32'h0000040C);
        rd(A_RES, d); check("fifo_first", d, 32'hA0000010);
        rd(A_STAT, d); check("stat_count3", d, 32'h00000308);
        rd(A_RES, d); check("fifo_second", d, 32'hA0000011);
        rd(A_RES, d); check("fifo_third", d, 32'hA0000012);
        rd(A_RES, d); check("fifo_fourth", d, 32'hA0000013);
        rd(A_STAT, d); check("stat_last_flags", d, 32'h0000003A);

        // unit never answers
        do_reset();
        resp_en = 1'b0;
        wr(A_CMD, 32'd1);
`ifdef POSIT_COP_SEQ_TIMEOUT_EN
        n = 0; s = 32'd1;
        while (s[0] && n < 200) begin rd(A_STAT, s); n++; end
        check("timeout_polls", n, 66);
        check("stat_after_timeout", s, 32'h0000000A);
`else
        repeat (100) rd(A_STAT, s);
        check("stays_busy", s, 32'h00000003);
`endif

        // reset during WAIT abandons the command
        do_reset();
        check_outs_zero("reset2");
        wr(A_OPA, 32'h00001234);
        wr(A_CMD, 32'd2);
        repeat (3) @(negedge clk);
        rst_i = 1'b1; req_i = 1'b1; addr_i = A_OPA;
        @(negedge clk);
        rst_i = 1'b0; req_i = 1'b0; addr_i = 32'd0;
        check_outs_zero("reset_mid");
        man_done = 3'b010;
        @(negedge clk);
        man_done = '0;
        repeat (3) @(negedge clk);
        rd(A_STAT, d); check("stat_after_reset_done", d, 32'h00000002);
        rd(A_OPA, d); check("opa_after_reset", d, 32'h0);

        // random traffic against the reference model
        do_reset();
        resp_en = 1'b1; resp_fixed_en = 1'b0;
        m_opa = 32'd0; m_opb = 32'd0; m_err = 1'b0; m_li = 1'b0; m_lz = 1'b0;
        q.delete(); busy_until = -1; pend_valid = 1'b0; pend_vis = 0; pend_entry = '0;
        for (int it = 0; it < 400; it++) begin
            c = cyc;
            if (pend_valid && c >= pend_vis) begin q.push_back(pend_entry); pend_valid = 1'b0; end
            idle = (c > busy_until);
            op = $urandom_range(0, 9);
            wdv = $urandom;
            bev = 4'($urandom_range(0, 15));
            case (op)
                0: begin m_opa = be_merge(m_opa, wdv, bev); bus(1'b1, A_OPA, wdv, bev, d, rv); check("r_wr_opa", d, 32'd0); end
                1: begin m_opb = be_merge(m_opb, wdv, bev); bus(1'b1, A_OPB, wdv, bev, d, rv); check("r_wr_opb", d, 32'd0); end
                2: begin rd(A_OPA, d); check("r_opa", d, m_opa); end
                3: begin rd(A_OPB, d); check("r_opb", d, m_opb); end
                4, 5: begin
                    cmdv = $urandom_range(0, 4);
                    if (idle && q.size() < 4 && cmdv >= 1 && cmdv <= NUM_OPS) begin
                        dly = $urandom_range(1, 6);
                        resp_delay = dly;
                        v = unit_fn(m_opa, m_opb, cmdv - 1);
                        pend_entry = {v[0], v[1], v};
                        pend_valid = 1'b1;
                        pend_vis = c + 3 + dly;
                        busy_until = c + 2 + dly;
                    end else begin
                        m_err = 1'b1;
                    end
                    wr(A_CMD, 32'(cmdv) | (wdv & 32'hFFFFFFF0));
                end
                6: begin
                    exp = {19'd0, 5'(q.size()), 2'd0, m_lz, m_li, m_err,
                           q.size() == 4, q.size() == 0, !idle};
                    rd(A_STAT, d); check("r_status", d, exp);
                end
                7: begin
                    if (q.size() > 0) begin
                        head = q.pop_front();
                        exp = head[31:0]; m_li = head[33]; m_lz = head[32];
                    end else begin
                        exp = 32'd0; m_err = 1'b1;
                    end
                    rd(A_RES, d); check("r_result", d, exp);
                end
                8: begin
                    if (wdv[3]) m_err = 1'b0;
                    wr(A_STAT, wdv);
                end
                default: repeat ($urandom_range(0, 4)) @(negedge clk);
            endcase
        end
        check("start_onehot", start_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
